// File: rtl/fifo_pkg.sv
// Shared types and seven-segment glyph constants for param_fifo.
package fifo_pkg;

    // Segment pattern, bit order abcdefg, 1 = segment lit.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;
    localparam seg_t SEG_A = 7'b1110111;
    localparam seg_t SEG_B = 7'b0011111;
    localparam seg_t SEG_C = 7'b1001110;
    localparam seg_t SEG_D = 7'b0111101;
    localparam seg_t SEG_E = 7'b1001111;
    localparam seg_t SEG_F = 7'b1000111;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment (abcdefg) decoder.
module seg7_hex_decode
    import fifo_pkg::*;
(
    input  logic [3:0] hex_in,
    output seg_t       seg_out
);

    always_comb begin
        seg_out = SEG_0;
        case (hex_in)
            4'h0: seg_out = SEG_0;
            4'h1: seg_out = SEG_1;
            4'h2: seg_out = SEG_2;
            4'h3: seg_out = SEG_3;
            4'h4: seg_out = SEG_4;
            4'h5: seg_out = SEG_5;
            4'h6: seg_out = SEG_6;
            4'h7: seg_out = SEG_7;
            4'h8: seg_out = SEG_8;
            4'h9: seg_out = SEG_9;
            4'hA: seg_out = SEG_A;
            4'hB: seg_out = SEG_B;
            4'hC: seg_out = SEG_C;
            4'hD: seg_out = SEG_D;
            4'hE: seg_out = SEG_E;
            4'hF: seg_out = SEG_F;
            default: seg_out = SEG_0;
        endcase
    end

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered read data, status flags and sticky errors.
// Define PARAM_FIFO_SEG_EN to get a registered seven-segment view of each popped word.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     write,
    input  logic                     read,
    input  logic [WIDTH-1:0]         fifo_in,
    output logic [WIDTH-1:0]         fifo_out,
    output logic                     rd_valid,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     underflow,
    output seg_t                     digitron_out
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  fifo_out_q, fifo_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ok_c, pop_ok_c;
    logic [WIDTH-1:0]  rd_word_c;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (32'(count_q) >= AFULL_TH);
    assign almost_empty = (32'(count_q) <= AEMPTY_TH);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
    always_comb begin
        pop_ok_c    = read && !fifo_empty;
        push_ok_c   = write && (!fifo_full || pop_ok_c);
        rd_word_c   = mem_q[rd_ptr_q];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_out_d  = fifo_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            rd_valid_d  = pop_ok_c;
            overflow_d  = overflow_q | (write & ~push_ok_c);
            underflow_d = underflow_q | (read & fifo_empty);
            if (pop_ok_c) begin
                rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                fifo_out_d = rd_word_c;
            end
            if (push_ok_c) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_out_q  <= fifo_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define valid contents.
    always_ff @(posedge clock) begin
        if (push_ok_c && !flush) begin
            mem_q[wr_ptr_q] <= fifo_in;
        end
    end

    assign fifo_out   = fifo_out_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef PARAM_FIFO_SEG_EN
    logic [3:0] seg_nib_c;
    seg_t       seg_pat_c;
    seg_t       seg_q, seg_d;

    // Decode the word being popped so the display lands together with fifo_out.
    assign seg_nib_c = 4'(rd_word_c);

    seg7_hex_decode u_seg7_hex_decode (
        .hex_in  (seg_nib_c),
        .seg_out (seg_pat_c)
    );

    always_comb begin
        seg_d = seg_q;
        if (pop_ok_c && !flush) begin
            seg_d = seg_pat_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign digitron_out = seg_q;
`else
    assign digitron_out = '0;
`endif

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 128, number of entries (power of two, >=2); address width ADDR_W = clog2(DEPTH), derived internally.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL have parameter AEMPTY_TH, default 4, almost-empty threshold in entries.
REQ-005 SHALL have ports: clock  in  1  single clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: flush  in  1  synchronous clear; write  in  1  push request; read  in  1  pop request; fifo_in  in  WIDTH  push data.
REQ-007 SHALL have ports: fifo_out  out  WIDTH  popped data (registered); rd_valid  out  1  one-cycle pulse marking new fifo_out.
REQ-008 SHALL have ports: fifo_empty, fifo_full, almost_empty, almost_full  out  1 each; fifo_count  out  ADDR_W+1  occupancy.
REQ-009 SHALL have ports: overflow, underflow  out  1  sticky error flags; digitron_out  out  7  seven-segment pattern, bit order abcdefg, 1 = segment lit.

Function
REQ-010 All DEPTH entries SHALL be usable; fifo_full = (fifo_count == DEPTH), fifo_empty = (fifo_count == 0).
REQ-011 almost_full SHALL be (fifo_count >= AFULL_TH); almost_empty SHALL be (fifo_count <= AEMPTY_TH); all four status flags combinational from fifo_count.
REQ-012 Push accepted at a rising edge iff write=1 and (not full, or read accepted in the same cycle); accepted push stores fifo_in at write pointer.
REQ-013 Pop accepted iff read=1 and not empty; fifo_out SHALL show popped word after that edge, rd_valid=1 for exactly that following cycle, fifo_out held until next accepted pop.
REQ-014 Read latency SHALL be one clock: data written at edge N is poppable by read asserted for edge N+1 or later; no write-to-read bypass when empty.
REQ-015 read=write=1 when empty: push accepted, pop rejected, underflow set; when full: both accepted, count unchanged; otherwise both accepted, count unchanged.
REQ-016 write=1 while full with no accepted pop SHALL drop the data and set overflow; read=1 while empty SHALL set underflow.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 by natural ADDR_W-bit rollover; fifo_count SHALL never exceed DEPTH or go below 0.
REQ-018 flush=1 SHALL, at the edge, zero pointers, fifo_count, overflow, underflow, rd_valid; overrides read/write that cycle; fifo_out and digitron_out hold.
REQ-019 overflow/underflow SHALL remain set until flush or reset.

Reset
REQ-020 reset=0 SHALL asynchronously force pointers, fifo_count, fifo_out, rd_valid, overflow, underflow to 0; digitron_out to pattern of 0 (1111110) when REQ-022 applies.
REQ-021 Storage array contents SHALL NOT be reset; reset mid-operation discards all queued entries.

Configuration
REQ-022 With macro PARAM_FIFO_SEG_EN defined, digitron_out SHALL be a register updated on each accepted pop with the hex decode of fifo_out[3:0] (WIDTH<4 zero-extended).
REQ-023 Without PARAM_FIFO_SEG_EN, digitron_out SHALL be constant 7'b0000000 and no decoder logic SHALL be instantiated.
REQ-024 Decode table 0-F SHALL be: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.

Structure
REQ-025 Package fifo_pkg SHALL hold the 16 segment pattern constants and a 7-bit segment-pattern typedef.
REQ-026 Sub-module seg7_hex_decode (4-bit in, 7-bit out, combinational) SHALL implement REQ-024 and be instantiated only under PARAM_FIFO_SEG_EN.

Verification (WIDTH=4, DEPTH=128, AFULL_TH=124, AEMPTY_TH=4)
REQ-027 Reset, push 0x1..0xA, pop 10 -> fifo_out 0x1..0xA in order, rd_valid 10 pulses, fifo_empty=1, digitron_out ends 1110111.
REQ-028 Push 128 words -> fifo_full=1, fifo_count=128, almost_full from count 124; 129th push -> overflow=1, count stays 128, later pops return original 128 words.
REQ-029 Empty FIFO, read=write=1 with fifo_in=0x5 -> count=1, underflow=1, rd_valid=0; next cycle read -> fifo_out=0x5.
REQ-030 Full FIFO, read=write=1 for 200 cycles -> count stays 128, no overflow, pointers wrap, data order preserved.
REQ-031 Count 50, assert reset=0 between edges -> outputs zero immediately; flush at count 50 -> count 0, flags cleared, fifo_out unchanged.
